rangefinder_sopc_cpu_div_cell: RTL and testbench

//  Iterative radix-2 restoring divider: the inverse-operation companion to the CPU multiply cell.

---
 rtl/rangefinder_sopc_cpu_div_cell_pkg.sv | 13 +
 rtl/rangefinder_sopc_cpu_div_cell_if.sv | 26 ++
 rtl/rangefinder_sopc_cpu_div_step.sv | 21 ++
 rtl/rangefinder_sopc_cpu_div_cell.sv | 155 +++++++++++++++
 tb/tb_rangefinder_sopc_cpu_div_cell.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/rangefinder_sopc_cpu_div_cell_pkg.sv
// Shared constants for the A-stage iterative divider: FSM state encoding and default operand width.
package rangefinder_sopc_cpu_div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/rangefinder_sopc_cpu_div_cell_if.sv
// Divider request/result bundle; the CPU side is the master, the divide cell is the slave.
interface rangefinder_sopc_cpu_div_cell_if
    import rangefinder_sopc_cpu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             A_div_start;
    logic [WIDTH-1:0] A_div_src1;
    logic [WIDTH-1:0] A_div_src2;
    logic             A_div_signed;
    logic             A_div_busy;
    logic             A_div_done;
    logic [WIDTH-1:0] A_div_quot;
    logic [WIDTH-1:0] A_div_rem;
    logic             A_div_by_zero;

    modport master (
        output A_div_start, A_div_src1, A_div_src2, A_div_signed,
        input  A_div_busy, A_div_done, A_div_quot, A_div_rem, A_div_by_zero
    );

    modport slave (
        input  A_div_start, A_div_src1, A_div_src2, A_div_signed,
        output A_div_busy, A_div_done, A_div_quot, A_div_rem, A_div_by_zero
    );
endinterface

// File: rtl/rangefinder_sopc_cpu_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, keep or restore.
module rangefinder_sopc_cpu_div_step
    import rangefinder_sopc_cpu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_dvd_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem_next,
    output logic             o_q_bit
);
    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;

    // Full remainder is shifted so divisors above 2^(WIDTH-1) still work.
    assign w_shifted  = {i_rem, i_dvd_bit};
    assign w_diff     = w_shifted - {1'b0, i_divisor};
    assign o_q_bit    = ~w_diff[WIDTH];
    assign o_rem_next = o_q_bit ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
endmodule

// File: rtl/rangefinder_sopc_cpu_div_cell.sv
// Radix-2 restoring divider, fixed WIDTH+1 cycle latency from start to done.
// Define RANGEFINDER_CPU_DIV_SIGNED_EN to enable two's-complement division via A_div_signed.
module rangefinder_sopc_cpu_div_cell
    import rangefinder_sopc_cpu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset_n,
    rangefinder_sopc_cpu_div_cell_if.slave div_if
);
    localparam int CNT_W = $clog2(WIDTH);

    div_state_t       r_state;
    div_state_t       w_state_next;
    logic             w_accept;
    logic             w_busy;
    logic             w_last;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_rem_acc;
    logic             r_by_zero_op;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_by_zero;
    logic             r_done;
    logic [WIDTH-1:0] w_rem_next;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_quot_mag;
    logic [WIDTH-1:0] w_mag1;
    logic [WIDTH-1:0] w_mag2;
    logic [WIDTH-1:0] w_quot_fix;
    logic [WIDTH-1:0] w_rem_fix;

    rangefinder_sopc_cpu_div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem      (r_rem_acc),
        .i_dvd_bit  (r_dvd[WIDTH-1]),
        .i_divisor  (r_divisor),
        .o_rem_next (w_rem_next),
        .o_q_bit    (w_q_bit)
    );

    // The dividend register doubles as the quotient shift register.
    assign w_quot_mag = {r_dvd[WIDTH-2:0], w_q_bit};
    assign w_last     = (r_count == CNT_W'(WIDTH - 1));

`ifdef RANGEFINDER_CPU_DIV_SIGNED_EN
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_src1_raw;
    logic             w_neg1;
    logic             w_neg2;

    assign w_neg1 = div_if.A_div_signed & div_if.A_div_src1[WIDTH-1];
    assign w_neg2 = div_if.A_div_signed & div_if.A_div_src2[WIDTH-1];
    assign w_mag1 = w_neg1 ? (~div_if.A_div_src1 + 1'b1) : div_if.A_div_src1;
    assign w_mag2 = w_neg2 ? (~div_if.A_div_src2 + 1'b1) : div_if.A_div_src2;

    // MIN / -1 needs no special case: |MIN| / 1 = MIN and the signs cancel.
    assign w_quot_fix = r_by_zero_op ? '1 :
                        (r_neg_q ? (~w_quot_mag + 1'b1) : w_quot_mag);
    assign w_rem_fix  = r_by_zero_op ? r_src1_raw :
                        (r_neg_r ? (~w_rem_next + 1'b1) : w_rem_next);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_src1_raw <= '0;
        end else if (w_accept) begin
            r_neg_q    <= w_neg1 ^ w_neg2;
            r_neg_r    <= w_neg1;
            r_src1_raw <= div_if.A_div_src1;
        end
    end
`else
    logic w_unused_signed;

    assign w_unused_signed = div_if.A_div_signed;
    assign w_mag1          = div_if.A_div_src1;
    assign w_mag2          = div_if.A_div_src2;
    // A zero divisor naturally yields all-ones quotient and the dividend as remainder.
    assign w_quot_fix      = w_quot_mag;
    assign w_rem_fix       = w_rem_next;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_busy       = 1'b1;
        unique case (r_state)
            DIV_IDLE: begin
                w_busy = 1'b0;
                if (div_if.A_div_start) begin
                    w_accept     = 1'b1;
                    w_state_next = DIV_CALC;
                end
            end
            DIV_CALC: if (w_last) w_state_next = DIV_DONE;
            DIV_DONE: w_state_next = DIV_IDLE;
            default: begin
                w_busy       = 1'b0;
                w_state_next = DIV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count      <= '0;
            r_dvd        <= '0;
            r_divisor    <= '0;
            r_rem_acc    <= '0;
            r_by_zero_op <= 1'b0;
            r_quot       <= '0;
            r_rem        <= '0;
            r_by_zero    <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_count      <= '0;
                r_dvd        <= w_mag1;
                r_divisor    <= w_mag2;
                r_rem_acc    <= '0;
                r_by_zero_op <= (div_if.A_div_src2 == '0);
            end else if (r_state == DIV_CALC) begin
                r_count   <= r_count + CNT_W'(1);
                r_dvd     <= w_quot_mag;
                r_rem_acc <= w_rem_next;
                if (w_last) begin
                    r_quot    <= w_quot_fix;
                    r_rem     <= w_rem_fix;
                    r_by_zero <= r_by_zero_op;
                    r_done    <= 1'b1;
                end
            end
        end
    end

    assign div_if.A_div_busy    = w_busy;
    assign div_if.A_div_done    = r_done;
    assign div_if.A_div_quot    = r_quot;
    assign div_if.A_div_rem     = r_rem;
    assign div_if.A_div_by_zero = r_by_zero;
endmodule

// File: tb/tb_rangefinder_sopc_cpu_div_cell.sv
// Directed bench for the iterative divider: latency, results, ignored starts, reset abort.
module tb_rangefinder_sopc_cpu_div_cell;
    import rangefinder_sopc_cpu_div_pkg::*;

    localparam int W = DIV_WIDTH;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    rangefinder_sopc_cpu_div_cell_if #(.WIDTH(W)) div_if ();

    rangefinder_sopc_cpu_div_cell #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .div_if  (div_if)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one op; inject_at > 0 raises a spurious start in that cycle of the op.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sgn, input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic ebz, input int inject_at);
        int lat;
        int busy_lo;
        @(negedge clk);
        div_if.A_div_start  = 1'b1;
        div_if.A_div_src1   = a;
        div_if.A_div_src2   = b;
        div_if.A_div_signed = sgn;
        @(posedge clk);
        #1;
        div_if.A_div_start = 1'b0;
        lat     = 1;
        busy_lo = 0;
        while (!div_if.A_div_done && lat < 100) begin
            if (!div_if.A_div_busy) busy_lo++;
            if (lat == inject_at) begin
                div_if.A_div_start = 1'b1;
                div_if.A_div_src1  = 7;
                div_if.A_div_src2  = 7;
            end
            @(posedge clk);
            #1;
            div_if.A_div_start = 1'b0;
            lat++;
        end
        if (!div_if.A_div_busy) busy_lo++;
        $display("%s: %0h / %0h -> quot=0x%08h rem=0x%08h by_zero=%0b latency=%0d",
                 tag, a, b, div_if.A_div_quot, div_if.A_div_rem, div_if.A_div_by_zero, lat);
        check({tag, " latency"}, lat, W + 1);
        check({tag, " busy"}, busy_lo, 0);
        check({tag, " quot"}, div_if.A_div_quot, eq);
        check({tag, " rem"}, div_if.A_div_rem, er);
        check({tag, " by_zero"}, div_if.A_div_by_zero, ebz);
        @(posedge clk);
        #1;
        check({tag, " done_pulse"}, div_if.A_div_done, 0);
        check({tag, " busy_after"}, div_if.A_div_busy, 0);
        check({tag, " quot_hold"}, div_if.A_div_quot, eq);
    endtask

    initial begin
        int saw_done;
        int lat;
        div_if.A_div_start  = 1'b0;
        div_if.A_div_src1   = '0;
        div_if.A_div_src2   = '0;
        div_if.A_div_signed = 1'b0;

        #12;
        check("reset busy", div_if.A_div_busy, 0);
        check("reset done", div_if.A_div_done, 0);
        check("reset quot", div_if.A_div_quot, 0);
        check("reset rem", div_if.A_div_rem, 0);
        check("reset by_zero", div_if.A_div_by_zero, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        run_op("100/7", 100, 7, 1'b0, 14, 2, 1'b0, 0);
        run_op("5/0", 5, 0, 1'b0, 32'hFFFF_FFFF, 5, 1'b1, 0);
        run_op("max/1 restart", 32'hFFFF_FFFF, 1, 1'b0, 32'hFFFF_FFFF, 0, 1'b0, 10);

        // Abort an op at cycle 15 with reset; outputs must clear immediately.
        @(negedge clk);
        div_if.A_div_start = 1'b1;
        div_if.A_div_src1  = 1000;
        div_if.A_div_src2  = 3;
        @(posedge clk);
        #1;
        div_if.A_div_start = 1'b0;
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        reset_n = 1'b0;
        #1;
        $display("reset abort: busy=%0b done=%0b quot=0x%08h rem=0x%08h",
                 div_if.A_div_busy, div_if.A_div_done, div_if.A_div_quot, div_if.A_div_rem);
        check("abort busy", div_if.A_div_busy, 0);
        check("abort quot", div_if.A_div_quot, 0);
        check("abort rem", div_if.A_div_rem, 0);
        check("abort by_zero", div_if.A_div_by_zero, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n  = 1'b1;
        saw_done = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (div_if.A_div_done) saw_done++;
        end
        check("abort no_done", saw_done, 0);

        run_op("9/3", 9, 3, 1'b0, 3, 0, 1'b0, 0);
        run_op("big divisor", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1, 1, 1'b0, 0);
        run_op("divisor > dividend", 32'h8000_0000, 32'h8000_0001, 1'b0, 0, 32'h8000_0000, 1'b0, 0);
        run_op("shift pattern", 32'h1234_5678, 32'h100, 1'b0, 32'h0012_3456, 32'h78, 1'b0, 0);
`ifdef RANGEFINDER_CPU_DIV_SIGNED_EN
        run_op("s -7/2", 32'hFFFF_FFF9, 2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 0);
        run_op("s min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 0, 1'b0, 0);
        run_op("s 7/-2", 7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 1, 1'b0, 0);
        run_op("s -7/0", 32'hFFFF_FFF9, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 0);
`else
        run_op("u -7/2", 32'hFFFF_FFF9, 2, 1'b1, 32'h7FFF_FFFC, 1, 1'b0, 0);
        run_op("u min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 32'h8000_0000, 1'b0, 0);
`endif

        // A start raised during the done cycle is ignored; accepted once back in idle.
        @(negedge clk);
        div_if.A_div_start  = 1'b1;
        div_if.A_div_src1   = 20;
        div_if.A_div_src2   = 6;
        div_if.A_div_signed = 1'b0;
        @(posedge clk);
        #1;
        div_if.A_div_start = 1'b0;
        lat = 1;
        while (!div_if.A_div_done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("20/6 latency", lat, W + 1);
        check("20/6 quot", div_if.A_div_quot, 3);
        check("20/6 rem", div_if.A_div_rem, 2);
        div_if.A_div_start = 1'b1;
        div_if.A_div_src1  = 1;
        div_if.A_div_src2  = 1;
        @(posedge clk);
        #1;
        check("done-cycle start ignored", div_if.A_div_busy, 0);
        @(posedge clk);
        #1;
        div_if.A_div_start = 1'b0;
        check("idle start accepted", div_if.A_div_busy, 1);
        lat = 1;
        while (!div_if.A_div_done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        $display("back-to-back 1/1: quot=0x%08h rem=0x%08h latency=%0d",
                 div_if.A_div_quot, div_if.A_div_rem, lat);
        check("1/1 latency", lat, W + 1);
        check("1/1 quot", div_if.A_div_quot, 1);
        check("1/1 rem", div_if.A_div_rem, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
